choice_update_unit: RTL
=======================

// Module: choice_update_unit
// PURPOSE
//  Producer side of the choice-predictor training interface. Tracks in-flight branch predictions,
//  owns the speculative 12-bit path history, and at in-order resolution emits {index, outcome}
//  training writes for the choice table. Restores history and flushes younger entries on mispredict.
//  Sits between fetch/predict (push side) and branch resolution (pop side).
// PARAMETERS
//  HIST_W  12  path-history width; equals choice-table index width
//  DEPTH   8   in-flight entries; power of 2, >=2
//  CNT_W   16  stats counter width (used only with CHOICE_UPD_STATS_EN)
// PORTS
//  clock        in   1               rising-edge clock
//  reset        in   1               asynchronous, active-low reset
//  pred_valid   in   1               new prediction offered
//  pred_ready   out  1               = !full
//  pred_taken   in   1               final (tournament-selected) direction
//  pred_local   in   1               local-predictor direction
//  pred_global  in   1               global-predictor direction
//  ghr_out      out  HIST_W          current speculative path history; choice-table lookup index
//  res_valid    in   1               oldest in-flight branch resolves this cycle
//  res_taken    in   1               actual direction
//  upd_valid    out  1               choice-table training write valid
//  upd_index    out  HIST_W          history snapshot taken at prediction time
//  upd_choice   out  1               1 = global was correct, 0 = local was correct
//  flush        out  1               mispredict pulse; wrong-path entries discarded
//  occupancy    out  $clog2(DEPTH)+1 live entry count
//  res_err      out  1               sticky: res_valid seen while empty
// BEHAVIOUR
//  Reset: ghr_out=0, occupancy=0, pred_ready=1, upd_valid=0, upd_index=0, upd_choice=0, flush=0, res_err=0.
//  Push (pred_valid & pred_ready): enqueue {ghr_out, pred_taken, pred_local, pred_global};
//   next cycle ghr_out = {ghr_out[HIST_W-2:0], pred_taken}.
//  Pop (res_valid & !empty): dequeue head H.
//   - H.local != H.global: next cycle upd_valid=1, upd_index=H.snap, upd_choice=(H.global==res_taken).
//   - H.local == H.global: no training write (upd_valid=0).
//   - H.taken != res_taken (mispredict): next cycle flush=1, queue emptied (occupancy=0),
//     ghr_out = {H.snap[HIST_W-2:0], res_taken}.
//  All outputs are registered; training and flush latency is 1 cycle after the resolving edge.
//  Same-cycle push+pop, no mispredict: both occur; occupancy unchanged; history shifts by pred_taken.
//  Same-cycle push+pop, mispredict: the pushed entry counts as wrong-path, is handshaken
//   (pred_ready=1), then dropped. Restored history wins; no shift by pred_taken.
//  Full: pred_ready=0 and push ignored, even when a pop occurs the same cycle (no combinational path).
//  Empty pop: ignored, no update, res_err set until reset.
//  Pointers wrap mod DEPTH. Occupancy saturates at DEPTH by construction.
//  Reset asserted mid-operation clears queue, history, and outputs immediately (asynchronously).
// CONFIGURATION
//  CHOICE_UPD_STATS_EN defined: adds outputs stat_mispred[CNT_W] and stat_train[CNT_W].
//   Each counts the corresponding event, saturates at all-ones, and resets to 0.
//  CHOICE_UPD_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  choice_pkg: HIST_W_DEF=12; typedef struct packed {logic [HIST_W-1:0] snap; logic taken, local_p, global_p;} inflight_t.
//  Sub-module choice_inflight_fifo: DEPTH-entry FIFO of inflight_t with push, pop, and a single-cycle clear.
//  The top level holds history, training, flush, and stats logic.
// TESTING
//  1 Reset, then 3 pushes taken=1,0,1 with local=global -> ghr_out=12'h005, occupancy=3, no upd_valid.
//  2 Push local=1, global=0, taken=1 at ghr=12'h0A3; resolve taken=0 -> next cycle upd_valid=1,
//    upd_index=12'h0A3, upd_choice=1, flush=1, ghr_out=12'h146, occupancy=0.
//  3 Fill to DEPTH=8 -> pred_ready=0. Push plus correct resolve same cycle -> push ignored, occupancy=7.
//  4 Occupancy=2, correct resolve plus push same cycle -> occupancy=2, history shifted once.
//  5 res_valid while empty -> res_err=1 and stays 1. Reset deasserts it.
//  6 Assert reset mid-stream with occupancy=5 -> all outputs return to reset values at once.
//    With CHOICE_UPD_STATS_EN, run 70000 mispredicts -> stat_mispred=16'hFFFF.

Source files
------------

// File: rtl/choice_pkg.sv
`default_nettype none
// ============================================================================
// Module   : choice_pkg
// Purpose  : Shared types and defaults for the choice-predictor update path.
// Revision : 1.0  initial release
// ============================================================================
package choice_pkg;

  localparam int HIST_W_DEF = 12;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 16;

  // One in-flight prediction: history snapshot plus the three directions.
  typedef struct packed {
    logic [HIST_W_DEF-1:0] snap;
    logic                  taken;
    logic                  local_p;
    logic                  global_p;
  } inflight_t;

endpackage
`default_nettype wire

// File: rtl/choice_inflight_fifo.sv
`default_nettype none
// ============================================================================
// Module   : choice_inflight_fifo
// Purpose  : DEPTH-entry FIFO of in-flight predictions with single-cycle clear.
// Revision : 1.0  initial release
// ============================================================================
module choice_inflight_fifo
  import choice_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  inflight_t              din,
  output inflight_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(DEPTH);

  inflight_t            r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 w_push;
  logic                 w_pop;

  // Clear wins: an entry pushed in the clearing cycle is wrong-path.
  assign w_push = push & ~full & ~clear;
  assign w_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_full);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/choice_update_unit.sv
`default_nettype none
// ============================================================================
// Module   : choice_update_unit
// Purpose  : Tracks in-flight predictions, owns speculative path history and
//            emits choice-table training writes at in-order resolution.
//            Optional counters enabled by CHOICE_UPD_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module choice_update_unit
  import choice_pkg::*;
#(
  parameter int HIST_W = HIST_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic                   pred_taken,
  input  logic                   pred_local,
  input  logic                   pred_global,
  output logic [HIST_W-1:0]      ghr_out,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   upd_valid,
  output logic [HIST_W-1:0]      upd_index,
  output logic                   upd_choice,
  output logic                   flush,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   res_err
`ifdef CHOICE_UPD_STATS_EN
  ,
  output logic [CNT_W-1:0]       stat_mispred,
  output logic [CNT_W-1:0]       stat_train
`endif
);

  logic [HIST_W-1:0]      r_ghr;
  logic                   r_upd_valid;
  logic [HIST_W-1:0]      r_upd_index;
  logic                   r_upd_choice;
  logic                   r_flush;
  logic                   r_res_err;

  inflight_t              w_din;
  inflight_t              w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_mispred;
  logic                   w_train;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign pred_ready = ~w_full;
  assign w_push     = pred_valid & ~w_full;
  assign w_pop      = res_valid & ~w_empty;
  assign w_mispred  = w_pop & (w_head.taken != res_taken);
  assign w_train    = w_pop & (w_head.local_p != w_head.global_p);

  always_comb begin
    w_din          = '0;
    w_din.snap     = r_ghr;
    w_din.taken    = pred_taken;
    w_din.local_p  = pred_local;
    w_din.global_p = pred_global;
  end

  choice_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_mispred),
    .din   (w_din),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ghr        <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_index  <= '0;
      r_upd_choice <= 1'b0;
      r_flush      <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      r_upd_valid <= w_train;
      if (w_train) begin
        r_upd_index  <= w_head.snap;
        r_upd_choice <= (w_head.global_p == res_taken);
      end
      r_flush <= w_mispred;
      if (res_valid && w_empty) begin
        r_res_err <= 1'b1;
      end
      // Restored history takes priority over a same-cycle wrong-path push.
      if (w_mispred) begin
        r_ghr <= {w_head.snap[HIST_W-2:0], res_taken};
      end else if (w_push) begin
        r_ghr <= {r_ghr[HIST_W-2:0], pred_taken};
      end
    end
  end

  assign ghr_out    = r_ghr;
  assign upd_valid  = r_upd_valid;
  assign upd_index  = r_upd_index;
  assign upd_choice = r_upd_choice;
  assign flush      = r_flush;
  assign occupancy  = w_count;
  assign res_err    = r_res_err;

`ifdef CHOICE_UPD_STATS_EN
  logic [CNT_W-1:0] r_stat_mispred;
  logic [CNT_W-1:0] r_stat_train;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_mispred <= '0;
      r_stat_train   <= '0;
    end else begin
      if (w_mispred && (r_stat_mispred != '1)) r_stat_mispred <= r_stat_mispred + 1'b1;
      if (w_train && (r_stat_train != '1))     r_stat_train   <= r_stat_train + 1'b1;
    end
  end

  assign stat_mispred = r_stat_mispred;
  assign stat_train   = r_stat_train;
`endif

endmodule
`default_nettype wire
